// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared seven-segment tables, converter states and parameter checks
package seg_scan_driver_pkg;

   // Active-high g..a; the top applies output polarity.
   localparam logic [6:0] SEG_OVERFLOW = 7'h40;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_SHIFT = 2'd1,
      CONV_DONE  = 2'd2
   } conv_state_e;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      s = 7'h00;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   function automatic bit num_digits_ok(input int n);
      return (n >= 2) && (n <= 8);
   endfunction

   // BCD digits needed to hold any 4*n-bit binary value, with margin for overflow detection.
   function automatic int bcd_digits(input int n);
      return n + n / 4 + 1;
   endfunction

endpackage

// File: rtl/seg_scan_driver_bin_to_bcd_seq.sv
// rtl/seg_scan_driver_bin_to_bcd_seq.sv - sequential shift-add-3 binary to BCD converter
// One input bit per cycle; done pulses for one cycle with bcd/overflow valid.
module bin_to_bcd_seq
   import seg_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    overflow
);
   localparam int BW = 4 * NUM_DIGITS;
   localparam int BD = bcd_digits(NUM_DIGITS);
   localparam int CW = $clog2(BW);

   conv_state_e     state_q, state_d;
   logic [BW-1:0]   sh_q, sh_d;
   logic [4*BD-1:0] acc_q, acc_d;
   logic [4*BD-1:0] adj;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_comb begin
      adj = acc_q;
      for (int i = 0; i < BD; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         CONV_SHIFT: begin
            acc_d = {adj[4*BD-2:0], sh_q[BW-1]};
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(BW - 1)) state_d = CONV_DONE;
         end
         default: begin
            if (start) begin
               sh_d    = bin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CONV_SHIFT;
            end else begin
               state_d = CONV_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CONV_IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy     = (state_q == CONV_SHIFT);
   assign done     = (state_q == CONV_DONE);
   assign bcd      = acc_q[BW-1:0];
   assign overflow = |acc_q[4*BD-1:BW];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with hex/decimal loading
// Loads land in a pending register and reach the display only at frame boundaries.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    value_valid,
   input  logic                    mode,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic                    busy,
   output logic [6:0]              display,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit
);
   localparam int DW = 4 * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{SEG_ACTIVE_LOW}};

   if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_num_digits
      $error("seg_scan_driver: NUM_DIGITS must be 2..8");
   end

   logic                   conv_busy, conv_done, conv_ovf;
   logic [DW-1:0]          conv_bcd;
   logic                   load, tick, frame;

   logic [REFRESH_DIV-1:0] cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [DW-1:0]          cap_val_q, cap_val_d;
   logic [NUM_DIGITS-1:0]  cap_dp_q, cap_dp_d;
   logic                   cap_blz_q, cap_blz_d;
   logic                   hex_pend_q, hex_pend_d;
   logic [DW-1:0]          pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic                   pend_blz_q, pend_blz_d, act_blz_q, act_blz_d;
   logic                   pend_ovf_q, pend_ovf_d, act_ovf_q, act_ovf_d;
   logic [6:0]             disp_q, disp_d;
   logic                   dp_q, dp_d;
   logic [NUM_DIGITS-1:0]  digit_q, digit_d;

   logic [6:0]             seg_on;
   logic                   dp_on, lead_zero, blank;

   assign load  = value_valid && !conv_busy;
   assign tick  = &cnt_q;
   assign frame = tick && (idx_q == IW'(NUM_DIGITS - 1));

   bin_to_bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_bcd (
      .clk      (clk),
      .rst_n    (rst),
      .start    (load && mode),
      .bin      (value),
      .busy     (conv_busy),
      .done     (conv_done),
      .bcd      (conv_bcd),
      .overflow (conv_ovf)
   );

   always_comb begin
      cnt_d      = cnt_q + REFRESH_DIV'(1);
      idx_d      = idx_q;
      cap_val_d  = cap_val_q;
      cap_dp_d   = cap_dp_q;
      cap_blz_d  = cap_blz_q;
      hex_pend_d = load && !mode;
      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_blz_d = pend_blz_q;
      pend_ovf_d = pend_ovf_q;
      disp_d     = disp_q;
      dp_d       = dp_q;
      digit_d    = digit_q;

      if (load) begin
         cap_val_d = value;
         cap_dp_d  = dp_in;
         cap_blz_d = blank_lz;
      end

      if (hex_pend_q) begin
         pend_dig_d = cap_val_q;
         pend_dp_d  = cap_dp_q;
         pend_blz_d = cap_blz_q;
         pend_ovf_d = 1'b0;
      end else if (conv_done) begin
         pend_dig_d = conv_ovf ? '0 : conv_bcd;
         pend_dp_d  = conv_ovf ? '0 : cap_dp_q;
         pend_blz_d = cap_blz_q;
         pend_ovf_d = conv_ovf;
      end

      // A pending write landing on the boundary edge is taken immediately.
      act_dig_d = frame ? pend_dig_d : act_dig_q;
      act_dp_d  = frame ? pend_dp_d  : act_dp_q;
      act_blz_d = frame ? pend_blz_d : act_blz_q;
      act_ovf_d = frame ? pend_ovf_d : act_ovf_q;

      if (tick) idx_d = frame ? '0 : idx_q + IW'(1);

      lead_zero = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j >= int'(idx_d) && act_dig_d[4*j +: 4] != 4'h0) lead_zero = 1'b0;
      end
      blank = act_blz_d && !act_ovf_d && (idx_d != '0) && lead_zero;

      if (act_ovf_d) begin
         seg_on = SEG_OVERFLOW;
         dp_on  = 1'b0;
      end else if (blank) begin
         seg_on = 7'h00;
         dp_on  = 1'b0;
      end else begin
         seg_on = seg_decode(act_dig_d[4*idx_d +: 4]);
         dp_on  = act_dp_d[idx_d];
      end

      if (tick) begin
         disp_d  = seg_on ^ SEG_OFF;
         dp_d    = dp_on ^ SEG_ACTIVE_LOW;
         digit_d = (NUM_DIGITS'(1) << idx_d) ^ DIG_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         cap_val_q  <= '0;
         cap_dp_q   <= '0;
         cap_blz_q  <= 1'b0;
         hex_pend_q <= 1'b0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_blz_q <= 1'b0;
         pend_ovf_q <= 1'b0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         act_blz_q  <= 1'b0;
         act_ovf_q  <= 1'b0;
         disp_q     <= SEG_OFF;
         dp_q       <= SEG_ACTIVE_LOW;
         digit_q    <= DIG_OFF;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         cap_val_q  <= cap_val_d;
         cap_dp_q   <= cap_dp_d;
         cap_blz_q  <= cap_blz_d;
         hex_pend_q <= hex_pend_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         pend_blz_q <= pend_blz_d;
         pend_ovf_q <= pend_ovf_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         act_blz_q  <= act_blz_d;
         act_ovf_q  <= act_ovf_d;
         disp_q     <= disp_d;
         dp_q       <= dp_d;
         digit_q    <= digit_d;
      end
   end

   assign busy    = conv_busy;
   assign display = disp_q;
   assign dp_out  = dp_q;
   assign digit   = digit_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver (4 digits, 4-cycle slots, active-low)
module tb_seg_scan_driver;
   localparam int ND = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic        value_valid = 1'b0;
   logic        mode = 1'b0;
   logic [3:0]  dp_in = '0;
   logic        blank_lz = 1'b0;
   logic        busy;
   logic [6:0]  display;
   logic        dp_out;
   logic [3:0]  digit;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [7:0] frame_got [4];

   typedef struct {
      logic [15:0] v;
      logic        m;
      logic [3:0]  dp;
      logic        blz;
      logic [27:0] segs;   // pin values {d3,d2,d1,d0}
      logic [3:0]  dpo;    // pin values, bit i = digit i
   } vec_t;
   vec_t vecs [9];

   always #5 clk = ~clk;

   seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(2), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .mode(mode),
      .dp_in(dp_in), .blank_lz(blank_lz), .busy(busy), .display(display),
      .dp_out(dp_out), .digit(digit)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Pin-level {dp_out, display} expected for digit i, from the display rules directly.
   function automatic logic [7:0] model_slot(input logic [15:0] v, input logic m,
                                              input logic [3:0] dp, input logic b, input int i);
      int num, p, msd;
      int dig [4];
      num = int'(v);
      if (m && num > 9999) return {1'b1, 7'h3F};
      p = 1;
      for (int k = 0; k < ND; k++) begin
         dig[k] = m ? (num / p) % 10 : (num >> (4 * k)) & 15;
         p = p * 10;
      end
      msd = 0;
      for (int k = 0; k < ND; k++) if (dig[k] != 0) msd = k;
      if (b && i > msd) return 8'hFF;
      return {~dp[i], ~seg_tab[dig[i]]};
   endfunction

   task automatic wait_digit(input logic [3:0] target, input string name);
      int n = 0;
      while (digit !== target && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, digit, target);
   endtask

   // Captures one whole frame starting at the first cycle of the digit-0 slot.
   task automatic sample_frame();
      int cnt [4];
      int bad = 0;
      int n = 0;
      for (int k = 0; k < 4; k++) begin
         cnt[k] = 0;
         frame_got[k] = 8'hxx;
      end
      while (digit === 4'b1110 && n < 40) begin @(negedge clk); n++; end
      wait_digit(4'b1110, "frame_sync");
      for (int s = 0; s < 16; s++) begin
         case (digit)
            4'b1110: begin frame_got[0] = {dp_out, display}; cnt[0]++; end
            4'b1101: begin frame_got[1] = {dp_out, display}; cnt[1]++; end
            4'b1011: begin frame_got[2] = {dp_out, display}; cnt[2]++; end
            4'b0111: begin frame_got[3] = {dp_out, display}; cnt[3]++; end
            default: bad++;
         endcase
         @(negedge clk);
      end
      check("one_hot", bad, 0);
      check("slot_len", {cnt[3][7:0], cnt[2][7:0], cnt[1][7:0], cnt[0][7:0]}, 32'h04040404);
   endtask

   task automatic do_load(input logic [15:0] v, input logic m, input logic [3:0] dp, input logic b);
      int n = 0;
      @(negedge clk);
      value = v; mode = m; dp_in = dp; blank_lz = b; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      value = 16'($urandom); mode = 1'($urandom); dp_in = 4'($urandom); blank_lz = 1'($urandom);
      if (m) begin
         while (busy && n < 40) begin n++; @(negedge clk); end
         check("busy_len", n, 16);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic verify_frame(input string name, input logic [15:0] v, input logic m,
                               input logic [3:0] dp, input logic b);
      sample_frame();
      for (int i = 0; i < ND; i++)
         check($sformatf("%s_d%0d", name, i), frame_got[i], model_slot(v, m, dp, b, i));
   endtask

   initial begin
      int n;
      logic [15:0] rv;
      logic rm;

      vecs[0] = '{16'h12AF, 1'b0, 4'h0,    1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
      vecs[1] = '{16'h2710, 1'b1, 4'hF,    1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF};
      vecs[2] = '{16'h0007, 1'b1, 4'b0011, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1110};
      vecs[3] = '{16'h0007, 1'b1, 4'h0,    1'b0, {7'h40, 7'h40, 7'h40, 7'h78}, 4'hF};
      vecs[4] = '{16'h0000, 1'b0, 4'h0,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
      vecs[5] = '{16'h0A00, 1'b0, 4'b1000, 1'b1, {7'h7F, 7'h08, 7'h40, 7'h40}, 4'hF};
      vecs[6] = '{16'h270F, 1'b1, 4'b0101, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1010};
      vecs[7] = '{16'h3456, 1'b0, 4'h0,    1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'hF};
      vecs[8] = '{16'hB0C0, 1'b0, 4'h0,    1'b1, {7'h03, 7'h40, 7'h46, 7'h40}, 4'hF};

      // Reset state and first tick
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_digit", digit, 4'hF);
      check("rst_display", display, 7'h7F);
      check("rst_dp", dp_out, 1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_tick_digit", digit, 4'hF);
      @(negedge clk);
      check("first_tick_digit", digit, 4'b1101);
      check("first_tick_display", display, 7'h40);
      check("first_tick_dp", dp_out, 1);

      // Table of fixed scenarios
      for (int k = 0; k < 9; k++) begin
         do_load(vecs[k].v, vecs[k].m, vecs[k].dp, vecs[k].blz);
         sample_frame();
         for (int i = 0; i < ND; i++)
            check($sformatf("vec%0d_d%0d", k, i), frame_got[i], {vecs[k].dpo[i], vecs[k].segs[7*i +: 7]});
      end

      // Decimal 1234 with a load request ignored while busy
      @(negedge clk);
      value = 16'h04D2; mode = 1'b1; dp_in = 4'h0; blank_lz = 1'b0; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         value_valid = (n == 5);
         if (n == 5) begin value = 16'h5555; mode = 1'b0; end
         n++;
         @(negedge clk);
      end
      value_valid = 1'b0;
      check("busy_len_1234", n, 16);
      repeat (20) @(negedge clk);
      sample_frame();
      check("dec1234_d0", frame_got[0], {1'b1, 7'h19});
      check("dec1234_d1", frame_got[1], {1'b1, 7'h30});
      check("dec1234_d2", frame_got[2], {1'b1, 7'h24});
      check("dec1234_d3", frame_got[3], {1'b1, 7'h79});

      // Mid-frame hex load: old data finishes the frame
      do_load(16'h1111, 1'b0, 4'h0, 1'b0);
      wait_digit(4'b1110, "mid_sync0");
      check("mid_pre_d0", display, 7'h79);
      wait_digit(4'b1101, "mid_sync1");
      value = 16'h2222; mode = 1'b0; dp_in = 4'h0; blank_lz = 1'b0; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      wait_digit(4'b1011, "mid_sync2");
      check("mid_old_d2", display, 7'h79);
      wait_digit(4'b0111, "mid_sync3");
      check("mid_old_d3", display, 7'h79);
      wait_digit(4'b1110, "mid_sync4");
      check("mid_new_d0", display, 7'h24);

      // Pending write landing exactly on the frame-boundary edge
      wait_digit(4'b0111, "edge_sync3");
      repeat (2) @(negedge clk);
      value = 16'h3333; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      wait_digit(4'b1110, "edge_sync0");
      check("edge_new_d0", display, 7'h30);

      // Reset in the middle of a conversion
      @(negedge clk);
      value = 16'h10E1; mode = 1'b1; dp_in = 4'hF; blank_lz = 1'b0; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_busy_before", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_digit", digit, 4'hF);
      check("abort_display", display, 7'h7F);
      check("abort_dp", dp_out, 1);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_busy_after", busy, 0);
      verify_frame("abort_zero", 16'h0000, 1'b0, 4'h0, 1'b0);

      // Random loads against the reference model
      for (int r = 0; r < 24; r++) begin
         rm = 1'($urandom);
         if (rm) begin
            rv = 16'($urandom_range(0, 11000));
            if ($urandom_range(0, 2) == 0) rv = 16'($urandom_range(0, 150));
         end else begin
            rv = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rv = rv >> $urandom_range(0, 15);
         end
         begin
            logic [3:0] rdp;
            logic rb;
            rdp = 4'($urandom);
            rb  = 1'($urandom);
            do_load(rv, rm, rdp, rb);
            verify_frame($sformatf("rand%0d", r), rv, rm, rdp, rb);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 16, so that one digit slot lasts 2^REFRESH_DIV clk cycles.
REQ-003 The block SHALL have parameter SEG_ACTIVE_LOW, default 1, so that 1 means segment, dp and digit outputs are driven low-active.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port value, input, 4*NUM_DIGITS bits: a hex nibble vector (nibble 0 = rightmost digit) or an unsigned binary number.
REQ-007 The block SHALL have port value_valid, input, 1 bit: a single-cycle load request.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = hex, 1 = decimal; it is sampled with value_valid.
REQ-009 The block SHALL have port dp_in, input, NUM_DIGITS bits: per-digit decimal points, sampled with value_valid.
REQ-010 The block SHALL have port blank_lz, input, 1 bit: leading-zero suppression enable, sampled with value_valid.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a decimal conversion is in progress.
REQ-012 The block SHALL have port display, output, 7 bits: segments g..a.
REQ-013 The block SHALL have port dp_out, output, 1 bit: the decimal point of the active digit.
REQ-014 The block SHALL have port digit, output, NUM_DIGITS bits: one-hot digit enable, where bit 0 is the rightmost digit.

Function
REQ-015 The block SHALL run a REFRESH_DIV-bit free-running counter; when the counter wraps, it SHALL issue a one-cycle tick.
REQ-016 On each tick, the block SHALL advance the scan index 0,1,...,NUM_DIGITS-1 and wrap to 0; the wrap to 0 is the frame boundary.
REQ-017 The digit, display and dp_out outputs SHALL be registered and SHALL change only on the cycle after a tick.
REQ-018 When value_valid=1 and busy=0, the block SHALL capture value, mode, dp_in and blank_lz; when busy=1, value_valid SHALL be ignored with no queueing.
REQ-019 In hex mode, the block SHALL copy the captured nibbles to the pending register in the cycle after capture.
REQ-020 In decimal mode, the block SHALL assert busy in the cycle after capture and run an iterative shift-add-3 conversion of one bit per cycle over 4*NUM_DIGITS cycles.
REQ-021 After the decimal conversion, the block SHALL write the BCD result to the pending register and deassert busy in the next cycle.
REQ-022 If a decimal value exceeds 10^NUM_DIGITS-1, the pending register SHALL hold the overflow pattern: every digit shows segment g only, and dp is forced off.
REQ-023 The block SHALL transfer the pending register to the active register only at a frame boundary, so a frame never shows mixed old and new data.
REQ-024 When a pending update arrives in the same cycle as a frame boundary, it SHALL take effect at that boundary.
REQ-025 With blank_lz=1, every digit above the most significant non-zero digit SHALL be blanked with segments and dp off; digit 0 SHALL never be blanked.
REQ-026 Blanking SHALL be evaluated on the active register, and blank_lz SHALL have no effect in the overflow state.
REQ-027 Nibble decode SHALL use the standard 0-F patterns (0=3F, 1=06, ... F=71, active-high g..a), inverted when SEG_ACTIVE_LOW=1.
REQ-028 Exactly one digit bit SHALL be active after the first tick.

Reset
REQ-029 While rst=0, the counter, scan index, pending register and active register SHALL be 0, and busy SHALL be 0.
REQ-030 While rst=0, all digit bits SHALL be inactive and display and dp_out SHALL be off (all ones when SEG_ACTIVE_LOW=1).
REQ-031 Reset asserted during a conversion SHALL abort it, with no partial result becoming visible.
REQ-032 After reset release, the block SHALL show all-zero data until the first load.

Structure
REQ-033 The segment decode table, the overflow pattern and a NUM_DIGITS legality check SHALL reside in the shared display package.
REQ-034 The decimal converter SHALL be the sub-module bin_to_bcd_seq, with ports start, bin, busy, done, bcd and overflow, and parametrised by NUM_DIGITS.

Verification (REFRESH_DIV=2, NUM_DIGITS=4, SEG_ACTIVE_LOW=1)
REQ-035 Bench scenario: reset, then load hex 0x12AF -> scan order digit 1110/F(0E), 1101/A(08), 1011/2(24), 0111/1(79), repeating every 16 cycles.
REQ-036 Bench scenario: decimal load 0x04D2 (1234) -> busy high for 16 cycles, then digits show 4,3,2,1 from the next frame boundary; a value_valid pulse while busy leaves the result unchanged.
REQ-037 Bench scenario: decimal load 0x2710 (10000) -> all four digits show 3F, and dp is off.
REQ-038 Bench scenario: decimal load 0x0007 with blank_lz=1 -> digit 0 shows 7 and digits 1-3 are dark; the same load with blank_lz=0 -> 0,0,0,7.
REQ-039 Bench scenario: new hex load mid-frame -> the old data completes the current frame and the new data starts exactly at index 0.
REQ-040 Bench scenario: rst pulse mid-conversion -> busy=0, digit=1111, display=7F asynchronously, and the old value is not restored.
